accum_readout_25: RTL and testbench
===================================

# accum_readout_25

Readout controller for the 25-bit MAC accumulator. It clears the accumulator and enables it for a programmed number of steps. It tracks overflow from the accumulator carry-out, then captures the final partial sum into an output register. The captured sum is drained over a valid/ready handshake. It sits between the subarray accumulator and the downstream result collector, and drives the accumulator's enable and clear.

## Interface
Parameters:
- WIDTH, 25: accumulator data width.
- CNT_W, 8: width of the step-count field.

Ports:
- sys_clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one accumulation window; ignored while busy.
- len  input  CNT_W  number of accumulation steps; sampled on accepted start; 0 is treated as 1.
- acc_data  input  WIDTH  accumulator registered output (running sum).
- acc_cout  input  1  accumulator adder carry-out for the current add.
- acc_en  output  1  drives accumulator sys_en.
- acc_clr  output  1  one-cycle clear request to the accumulator.
- busy  output  1  high from the accepted start until capture.
- out_valid  output  1  captured result available.
- out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
- out_data  output  WIDTH  captured sum.
- out_ovf  output  1  sticky overflow for the captured window.

## Operation
- FSM states are IDLE, CLEAR, ACCUM, SETTLE and HOLD. Reset forces IDLE.
- Reset values: acc_en=0, acc_clr=0, busy=0, out_valid=0, out_data=0, out_ovf=0. The step counter and the sticky flag are also cleared.
- IDLE: if start=1, latch max(len,1) into the counter, clear the sticky flag, and go to CLEAR.
- CLEAR: acc_clr=1 for exactly one cycle, then go to ACCUM.
- ACCUM: acc_en=1 every cycle.
  - sticky |= acc_cout each cycle.
  - The counter decrements each cycle; on the cycle where counter==1, go to SETTLE.
- SETTLE: acc_en=0 and acc_data holds the final sum. Capture is allowed if out_valid=0, or if out_valid=1 and out_ready=1 in this cycle.
  - If capture is allowed: out_data<=acc_data, out_ovf<=sticky (or the saturated value, see Configuration), out_valid<=1, then go to IDLE.
  - Otherwise go to HOLD.
- HOLD: acc_en=0, so the accumulator holds its value. Re-evaluate the capture condition every cycle. On capture go to IDLE.
- Output register: out_valid clears on handshake unless a capture happens in the same cycle. A capture in the same cycle refills the register with out_valid staying 1.
- busy=1 in CLEAR, ACCUM, SETTLE and HOLD.
- start while busy is dropped with no effect. start in IDLE is accepted even if out_valid=1 (the previous result is still pending).
- Arithmetic: out_data is taken directly from acc_data, with no width change. Overflow is a single sticky bit.

## Timing
- Accepted start at cycle 0 gives: CLEAR at cycle 1, ACCUM at cycles 2..L+1, SETTLE at cycle L+2, and out_valid=1 from cycle L+3 when unblocked. L = max(len,1).
- acc_en is high for exactly L cycles per window. acc_clr is high for exactly 1 cycle.
- The earliest next start is accepted in cycle L+3.
- Back-to-back windows: a second window's SETTLE can capture in the same cycle the first result handshakes, with no bubble.
- rst asserted in any state:
  - next cycle is IDLE, with acc_en=0 and acc_clr=0;
  - the pending result is discarded (out_valid=0);
  - the accumulator is not auto-cleared.

## Configuration
- Macro ACCUM_SAT_EN.
- Defined: if sticky=1 at capture, out_data<=25'h1FFFFFF (all ones). out_ovf still reports 1.
- Undefined: out_data is the wrapped acc_data value, and out_ovf flags the wrap.

## Test plan
- Reset, then start with len=4, out_ready=1 tied high, acc_data driven to 100. Required:
  - acc_clr=1 at cycle 1 only;
  - acc_en=1 at cycles 2..5;
  - out_valid=1 at cycle 7 with out_data=100, out_ovf=0.
- len=0 with start: acc_en is high exactly 1 cycle, and out_valid is asserted at cycle 4.
- acc_cout pulsed high for 1 ACCUM cycle with acc_data=25'h0000010 and len=3.
  - Without ACCUM_SAT_EN: out_ovf=1 and out_data=25'h0000010.
  - With ACCUM_SAT_EN: out_data=25'h1FFFFFF.
- First result held with out_ready=0, second window run with len=2:
  - FSM sits in HOLD, busy=1, acc_en=0;
  - raise out_ready for 1 cycle: first result handshakes, second is captured the same cycle, out_valid stays 1.
- start pulsed during ACCUM of a len=5 window: ignored, acc_en stays high exactly 5 cycles, and only one result is produced.
- rst asserted at ACCUM cycle 3 of len=8: next cycle acc_en=0, busy=0, out_valid=0. A new start then behaves as from reset.

Source files
------------

// File: rtl/accum_readout_25.sv
// accum_readout_25
// Readout controller for the 25-bit MAC accumulator. A run starts with a
// one-cycle clear of the accumulator. The accumulator is then enabled for a
// programmed number of steps, and carry-outs are collected into a sticky
// overflow flag. The final sum is captured into an output register that the
// result collector drains over a valid/ready handshake.
//
// Optional feature (macro ACCUM_SAT_EN):
//   defined   - a window that overflowed captures all ones instead of the sum
//   undefined - the wrapped sum is captured as-is; out_ovf flags the wrap
//
// Ports:
//   sys_clk    system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle request to run a window (ignored while busy)
//   len        step count, sampled on accepted start (0 behaves as 1)
//   acc_data   accumulator running sum
//   acc_cout   accumulator adder carry-out for the current add
//   acc_en     accumulator enable
//   acc_clr    one-cycle accumulator clear
//   busy       window in progress (accepted start until capture)
//   out_valid  captured result available
//   out_ready  consumer accepts the result
//   out_data   captured sum
//   out_ovf    sticky overflow of the captured window
module accum_readout_25 #(
    parameter int WIDTH = 25,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] acc_data,
    input  logic             acc_cout,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SETTLE,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic             capture;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A capture may happen when the output register is empty, or when it is
    // being drained in this same cycle. Draining and refilling in one cycle
    // avoids a bubble between back-to-back windows.
    always_comb begin
        state_nxt = state;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        busy      = 1'b1;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr   = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE, HOLD: begin
                capture   = !out_valid || out_ready;
                state_nxt = capture ? IDLE : HOLD;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt    <= (len == '0) ? CNT_W'(1) : len;
                sticky <= 1'b0;
            end else if (state == ACCUM) begin
                cnt    <= cnt - CNT_W'(1);
                sticky <= sticky | acc_cout;
            end

            if (capture) begin
                out_valid <= 1'b1;
`ifdef ACCUM_SAT_EN
                out_data  <= sticky ? {WIDTH{1'b1}} : acc_data;
`else
                out_data  <= acc_data;
`endif
                out_ovf   <= sticky;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_readout_25.sv
// tb_accum_readout_25
// Self-checking bench for accum_readout_25. Each window is run from its start
// cycle (cycle 0). Enable, clear and valid activity is recorded per cycle and
// then compared against a window-level model. In that model, L = max(len,1),
// the clear comes at cycle 1, enable covers cycles 2..L+1, and valid appears at
// cycle L+3. Overflow is the OR of the carries driven during the enable cycles.
// Honours ACCUM_SAT_EN the same way as the design.
module tb_accum_readout_25;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [24:0] acc_data;
    logic        acc_cout;
    logic        acc_en;
    logic        acc_clr;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_data;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    accum_readout_25 #(.WIDTH(25), .CNT_W(8)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .acc_data  (acc_data),
        .acc_cout  (acc_cout),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [24:0] model_data(input logic [24:0] d, input logic ovf);
`ifdef ACCUM_SAT_EN
        return ovf ? 25'h1FFFFFF : d;
`else
        return d;
`endif
    endfunction

    // Runs one window from the current cycle (cycle 0, design idle).
    // Returns on the cycle where out_valid is first seen, which is also the
    // earliest cycle in which the next start may be issued.
    // cout_mode: 0 none, 1 random, 2 single pulse at cycle 3.
    // stray_cycle: nonzero issues an extra start in that (busy) cycle.
    task automatic applyStimulus(input logic [7:0] len_v, input logic [24:0] data_v,
                                 input int cout_mode, input int stray_cycle,
                                 input string tag);
        int l_eff;
        bit cout_hist[64];
        int en_cnt    = 0;
        int clr_cnt   = 0;
        int first_en  = -1;
        int last_en   = -1;
        int clr_cyc   = -1;
        int valid_cyc = -1;
        logic busy1   = 1'b0;
        logic exp_ovf = 1'b0;

        l_eff = (len_v == 8'd0) ? 1 : int'(len_v);
        start    = 1'b1;
        len      = len_v;
        acc_data = data_v;
        acc_cout = 1'b0;
        for (int i = 0; i < 64; i++) cout_hist[i] = 1'b0;

        for (int c = 1; c <= 40 && valid_cyc < 0; c++) begin
            tick();
            if (c == 1) busy1 = busy;
            if (acc_en) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (acc_clr) begin
                clr_cnt++;
                if (clr_cyc < 0) clr_cyc = c;
            end
            if (out_valid) valid_cyc = c;

            start = (c == stray_cycle);
            if (start) len = 8'd1;
            case (cout_mode)
                1:       acc_cout = ($urandom_range(0, 7) == 0);
                2:       acc_cout = (c == 3);
                default: acc_cout = 1'b0;
            endcase
            cout_hist[c] = acc_cout;
        end
        start    = 1'b0;
        acc_cout = 1'b0;

        for (int c = 2; c <= l_eff + 1; c++) exp_ovf |= cout_hist[c];

        checkOutput({tag, ".busy_c1"},   32'(busy1), 32'd1);
        checkOutput({tag, ".clr_cnt"},   clr_cnt, 1);
        checkOutput({tag, ".clr_cyc"},   clr_cyc, 1);
        checkOutput({tag, ".en_cnt"},    en_cnt, l_eff);
        checkOutput({tag, ".en_first"},  first_en, 2);
        checkOutput({tag, ".en_last"},   last_en, l_eff + 1);
        checkOutput({tag, ".valid_cyc"}, valid_cyc, l_eff + 3);
        checkOutput({tag, ".busy_end"},  32'(busy), 32'd0);
        checkOutput({tag, ".data"},      32'(out_data), 32'(model_data(data_v, exp_ovf)));
        checkOutput({tag, ".ovf"},       32'(out_ovf), 32'(exp_ovf));
    endtask

    initial begin
        logic [24:0] data_a;
        logic [24:0] data_b;
        int extra_valid;
        int l_rand;
        int l_eff;
        int stray;

        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        acc_data  = 25'd0;
        acc_cout  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst.acc_en",    32'(acc_en), 32'd0);
        checkOutput("rst.acc_clr",   32'(acc_clr), 32'd0);
        checkOutput("rst.busy",      32'(busy), 32'd0);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.out_data",  32'(out_data), 32'd0);
        checkOutput("rst.out_ovf",   32'(out_ovf), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(8'd4, 25'd100, 0, 0, "len4");
        checkOutput("len4.data100", 32'(out_data), 32'd100);
        tick();
        checkOutput("len4.drained", 32'(out_valid), 32'd0);

        applyStimulus(8'd0, 25'($urandom), 0, 0, "len0");
        tick();

        applyStimulus(8'd3, 25'h0000010, 2, 0, "pulse");
        checkOutput("pulse.ovf_set", 32'(out_ovf), 32'd1);
        tick();

        // Stray start in the middle of ACCUM must not spawn a second window.
        applyStimulus(8'd5, 25'h0001234, 0, 3, "stray");
        extra_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) extra_valid++;
        end
        checkOutput("stray.extra", extra_valid, 0);

        // First result left pending; second window must park in HOLD.
        data_a = 25'h0ABCDE;
        data_b = 25'h155555;
        out_ready = 1'b0;
        applyStimulus(8'd3, data_a, 0, 0, "hold1");
        start    = 1'b1;
        len      = 8'd2;
        acc_data = data_b;
        tick();
        start = 1'b0;
        checkOutput("hold.clr", 32'(acc_clr), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("hold.settle_busy", 32'(busy), 32'd1);
        checkOutput("hold.settle_en",   32'(acc_en), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("hold.busy",  32'(busy), 32'd1);
            checkOutput("hold.en",    32'(acc_en), 32'd0);
            checkOutput("hold.valid", 32'(out_valid), 32'd1);
            checkOutput("hold.data_a", 32'(out_data), 32'(data_a));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("hold.swap_valid", 32'(out_valid), 32'd1);
        checkOutput("hold.swap_data",  32'(out_data), 32'(data_b));
        checkOutput("hold.swap_busy",  32'(busy), 32'd0);
        tick();
        checkOutput("hold.keep_valid", 32'(out_valid), 32'd1);
        checkOutput("hold.keep_data",  32'(out_data), 32'(data_b));

        // Reset in the third ACCUM cycle of a len=8 window with a result pending.
        start    = 1'b1;
        len      = 8'd8;
        acc_data = 25'h0000777;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("mrst.in_accum", 32'(acc_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst.acc_en",    32'(acc_en), 32'd0);
        checkOutput("mrst.acc_clr",   32'(acc_clr), 32'd0);
        checkOutput("mrst.busy",      32'(busy), 32'd0);
        checkOutput("mrst.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        applyStimulus(8'd2, 25'($urandom), 1, 0, "after_rst");

        for (int n = 0; n < 20; n++) begin
            l_rand = $urandom_range(0, 10);
            l_eff  = (l_rand == 0) ? 1 : l_rand;
            stray  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, l_eff + 2) : 0;
            applyStimulus(8'(l_rand), 25'($urandom), 1, stray, "rand");
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
